// File: rtl/id_exe_elastic_queue.sv
// id_exe_elastic_queue: DEPTH-entry elastic ID->EXE queue with flush/freeze/bubble handling and bubble statistics
module id_exe_elastic_queue #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         freeze,
  input  logic                         hazard_detected,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic [CTRL_W-1:0]            in_ctrl,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             bubble_cnt
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_W+CTRL_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop, bubble;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  // freeze reaches push, pop and bubble only through in_ready/pop gating
  always_comb begin
    in_ready = !freeze && count < CW'(DEPTH);
    push = in_valid && in_ready && !hazard_detected && !flush;
    pop = out_valid && out_ready && !freeze && !flush;
    bubble = in_valid && in_ready && hazard_detected && !flush;
    out_valid = count != '0;
    {out_ctrl, out_data} = out_valid ? mem[rd_ptr] : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      bubble_cnt <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        wr_ptr <= push ? inc(wr_ptr) : wr_ptr;
        rd_ptr <= pop ? inc(rd_ptr) : rd_ptr;
        count <= count + CW'(push) - CW'(pop);
      end
      if (bubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_ctrl, in_data};
  always_ff @(posedge clk)
    if (rst) assert (!(push && count == CW'(DEPTH)));
endmodule

// File: tb/tb_id_exe_elastic_queue.sv
// tb_id_exe_elastic_queue: scoreboard bench for a DEPTH=4 queue and a DEPTH=1, CNT_W=2 queue driven in parallel
module tb_id_exe_elastic_queue;
  logic clk = 0, rst = 0, flush = 0, freeze = 0, hz = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = '0;
  logic [7:0] in_ctrl = '0;
  logic a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_data, b_out_data;
  logic [7:0] a_out_ctrl, b_out_ctrl;
  logic [2:0] a_count;
  logic [0:0] b_count;
  logic [15:0] a_bub;
  logic [1:0] b_bub;
  int checks = 0, errors = 0;
  int ba = 0, bb = 0;
  logic [39:0] qa[$], qb[$];
  always #5 clk = ~clk;
  id_exe_elastic_queue #(.DATA_W(32), .CTRL_W(8), .DEPTH(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .hazard_detected(hz),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .count(a_count), .bubble_cnt(a_bub));
  id_exe_elastic_queue #(.DATA_W(32), .CTRL_W(8), .DEPTH(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .hazard_detected(hz),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .count(b_count), .bubble_cnt(b_bub));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [31:0] d);
    in_data = d;
    in_ctrl = d[7:0] ^ 8'h5A;
  endtask
  // Compare both DUTs against the scoreboard, then advance the model across one clock edge.
  task automatic cycle();
    bit ra, rb, pa, pb, oa, ob;
    logic [39:0] ha, hb;
    #1;
    ha = qa.size() != 0 ? qa[0] : '0;
    hb = qb.size() != 0 ? qb[0] : '0;
    ra = !freeze && qa.size() < 4;
    rb = !freeze && qb.size() < 1;
    chk("a_count", a_count, qa.size());
    chk("a_in_ready", a_in_ready, ra);
    chk("a_out_valid", a_out_valid, qa.size() != 0);
    chk("a_out_data", a_out_data, ha[31:0]);
    chk("a_out_ctrl", a_out_ctrl, ha[39:32]);
    chk("a_bubble_cnt", a_bub, ba);
    chk("b_count", b_count, qb.size());
    chk("b_in_ready", b_in_ready, rb);
    chk("b_out_valid", b_out_valid, qb.size() != 0);
    chk("b_out_data", b_out_data, hb[31:0]);
    chk("b_out_ctrl", b_out_ctrl, hb[39:32]);
    chk("b_bubble_cnt", b_bub, bb);
    pa = in_valid && ra && !hz && !flush;
    pb = in_valid && rb && !hz && !flush;
    oa = qa.size() != 0 && out_ready && !freeze && !flush;
    ob = qb.size() != 0 && out_ready && !freeze && !flush;
    if (hz && in_valid && ra && !flush && ba < 65535) ba++;
    if (hz && in_valid && rb && !flush && bb < 3) bb++;
    @(posedge clk);
    if (flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (oa) void'(qa.pop_front());
      if (pa) qa.push_back({in_ctrl, in_data});
      if (ob) void'(qb.pop_front());
      if (pb) qb.push_back({in_ctrl, in_data});
    end
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_count", a_count, 0);
    chk("reset_valid", a_out_valid, 0);
    rst = 1;
    cycle();
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      drive(32'hA0 + i);
      cycle();
    end
    chk("fill_count", a_count, 4);
    chk("fill_in_ready", a_in_ready, 0);
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 5; i++) cycle();
    chk("drain_valid", a_out_valid, 0);
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      drive(32'hB0 + i);
      cycle();
    end
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      drive(32'hC0 + i);
      cycle();
    end
    chk("wrap_count", a_count, 2);
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      drive(32'hD0 + i);
      cycle();
    end
    freeze = 0;
    chk("freeze_count", a_count, 2);
    out_ready = 0;
    drive(32'hE0);
    cycle();
    chk("preflush_count", a_count, 3);
    flush = 1;
    drive(32'hE1);
    cycle();
    flush = 0;
    in_valid = 0;
    chk("flush_count", a_count, 0);
    chk("flush_ctrl", a_out_ctrl, 0);
    cycle();
    in_valid = 1;
    hz = 1;
    for (int i = 0; i < 5; i++) begin
      drive(32'hF0 + i);
      cycle();
    end
    hz = 0;
    chk("hazard_count", a_count, 0);
    chk("hazard_bub_a", a_bub, 5);
    chk("hazard_bub_b_sat", b_bub, 3);
    for (int i = 0; i < 3; i++) begin
      drive(32'h10 + i);
      cycle();
    end
    in_valid = 0;
    chk("prereset_count", a_count, 3);
    #2 rst = 0;
    #1;
    chk("async_rst_valid", a_out_valid, 0);
    chk("async_rst_count", a_count, 0);
    chk("async_rst_bub_a", a_bub, 0);
    chk("async_rst_bub_b", b_bub, 0);
    chk("async_rst_ctrl", a_out_ctrl, 0);
    qa.delete();
    qb.delete();
    ba = 0;
    bb = 0;
    @(negedge clk);
    rst = 1;
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
